// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution engine: width functions,
// a log2 helper, a wide signed carrier type and the output clamp.
package conv_pkg;

    // Ceiling log2; conv_stream only calls it with n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // Unsigned pixel (zero-extended) times signed coefficient.
    function automatic int prod_w(input int pxl_w, input int coef_w);
        return pxl_w + coef_w + 1;
    endfunction

    // Room for K*K products without overflow.
    function automatic int acc_w(input int pxl_w, input int coef_w, input int k);
        return prod_w(pxl_w, coef_w) + clog2(k * k);
    endfunction

    // Wide signed carrier used for clamping at any parameterisation.
    typedef logic signed [63:0] wide_t;

    // Saturate to the output range: unsigned when relu, two's complement otherwise.
    function automatic wide_t clamp_sum(input wide_t v, input int pxl_w, input bit relu);
        wide_t lo, hi;
        if (relu) begin
            lo = '0;
            hi = (wide_t'(1) <<< pxl_w) - 1;
        end else begin
            hi = (wide_t'(1) <<< (pxl_w - 1)) - 1;
            lo = -hi - 1;
        end
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of delay: a DIM-deep circular buffer that advances only
// when en is high, so dout is the pixel written DIM enables ago.
module conv_line_buffer import conv_pkg::*; #(
    parameter int DIM = 28,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    localparam int PTR_W = clog2(DIM);

    logic [W-1:0]     mem [DIM];
    logic [PTR_W-1:0] ptr;

    assign dout = mem[ptr];

    // Storage overwrites the oldest entry; contents need no reset.
    always_ff @(posedge clk) begin
        if (en) mem[ptr] <= din;
    end

    // Circular write/read pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           ptr <= '0;
        else if (en && ptr == PTR_W'(DIM-1)) ptr <= '0;
        else if (en)                         ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/conv_stream.sv
// Streaming 2-D valid convolution, raster pixels in, one clamped result per
// fully covered KxK window out. Two pipeline stages (products, sum/clamp),
// both frozen together by downstream backpressure.
// Build option: define CONV_RELU_EN for an unsigned [0, 2^PXL_W-1] clamp;
// otherwise results are clamped to the signed PXL_W range.
module conv_stream import conv_pkg::*; #(
    parameter int DIM    = 28,
    parameter int K      = 5,
    parameter int PXL_W  = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PXL_W-1:0]        pxl_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    coef_we,
    input  logic [clog2(K*K)-1:0]   coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic [PXL_W-1:0]        pxl_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
);
    localparam int NTAP   = K * K;
    localparam int CNT_W  = clog2(DIM);
    localparam int PROD_W = prod_w(PXL_W, COEF_W);
    localparam int ACC_W  = acc_w(PXL_W, COEF_W, K);
`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                         adv, accept, window_done, frame_end, coef_hit;
    logic [CNT_W-1:0]             col, row;
    logic [K-1:0][PXL_W-1:0]      tap;
    logic [K-1:0][K-1:0][PXL_W-1:0] win, nwin;
    logic [NTAP-1:0][COEF_W-1:0]  coef, coef_eff;
    logic signed [PROD_W-1:0]     prod_d [NTAP];
    logic signed [PROD_W-1:0]     prod_q [NTAP];
    logic                         s1_vld, s1_last;
    logic signed [ACC_W-1:0]      sum, shifted;
    logic [PXL_W-1:0]             res;

    assign adv         = !out_valid || out_ready;
    assign in_ready    = adv;
    assign accept      = in_valid && adv;
    assign window_done = (row >= CNT_W'(K-1)) && (col >= CNT_W'(K-1));
    assign frame_end   = (row == CNT_W'(DIM-1)) && (col == CNT_W'(DIM-1));
    assign coef_hit    = coef_we && (int'(coef_addr) < NTAP);

    // Raster position of the pixel currently offered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CNT_W'(DIM-1)) begin
                col <= '0;
                row <= (row == CNT_W'(DIM-1)) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // tap[i] is the pixel i rows above the incoming one, same column.
    assign tap[0] = pxl_in;
    for (genvar g = 0; g < K-1; g++) begin : g_lb
        conv_line_buffer #(.DIM(DIM), .W(PXL_W)) u_lb (
            .clk   (clk),
            .reset (reset),
            .en    (accept),
            .din   (tap[g]),
            .dout  (tap[g+1])
        );
    end

    // Window including the incoming pixel: row 0 is the oldest line,
    // column K-1 is the newest column.
    always_comb begin
        nwin = win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) nwin[r][c] = win[r][c+1];
            nwin[r][K-1] = tap[K-1-r];
        end
    end

    // Window shift register; contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (accept) win <= nwin;
    end

    // Coefficient bank; writes land regardless of pipeline advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         coef <= '0;
        else if (coef_hit) coef[coef_addr] <= coef_data;
    end

    // A coefficient written on the accepting edge applies to that window.
    always_comb begin
        coef_eff = coef;
        if (coef_hit) coef_eff[coef_addr] = coef_data;
    end

    // Stage 1 products: zero-extended pixel times signed coefficient.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_d[r*K+c] = PROD_W'($signed({1'b0, nwin[r][c]}))
                              * PROD_W'($signed(coef_eff[r*K+c]));
            end
        end
    end

    // Stage 1 product registers (data path, no reset needed).
    always_ff @(posedge clk) begin
        if (adv) prod_q <= prod_d;
    end

    // Stage 1 valid/last flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else if (adv) begin
            s1_vld  <= accept && window_done;
            s1_last <= accept && frame_end;
        end
    end

    // Stage 2 combinational sum, arithmetic shift and saturation.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAP; i++) sum = sum + ACC_W'(prod_q[i]);
        shifted = sum >>> SHIFT;
        res     = PXL_W'(clamp_sum(wide_t'(shifted), PXL_W, RELU));
    end

    // Stage 2 output register, held while downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pxl_out   <= '0;
        end else if (adv) begin
            out_valid <= s1_vld;
            out_last  <= s1_last;
            pxl_out   <= res;
        end
    end

endmodule

// File: tb/tb_conv_stream.sv
// Scoreboard bench for conv_stream at DIM=28, K=5: expected results are
// computed from the bench's own image/kernel copy when the completing pixel
// is accepted and checked against outputs in arrival order.
module tb_conv_stream;
    localparam int DIM = 28;
    localparam int K   = 5;
    localparam int SH  = 0;
    localparam int NRES = (DIM-K+1)*(DIM-K+1);

    logic       clk, reset;
    logic [7:0] pxl_in;
    logic       in_valid, in_ready;
    logic       coef_we;
    logic [4:0] coef_addr;
    logic [7:0] coef_data;
    logic [7:0] pxl_out;
    logic       out_valid, out_ready, out_last;

    conv_stream #(.DIM(DIM), .K(K), .PXL_W(8), .COEF_W(8), .SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .pxl_in(pxl_in), .in_valid(in_valid),
        .in_ready(in_ready), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .pxl_out(pxl_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
        longint     cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     img [DIM][DIM];
    int     kern [K*K];
    int     n_assert = 0;
    int     n_fail = 0;
    int     n_out = 0;
    longint cyc = 0;
    bit     stall_mode = 0;
    bit     held_v = 0;
    logic [7:0] held_d;
    logic   held_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input int r, input int c);
        longint s;
        s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(img[r-K+1+i][c-K+1+j]) * kern[i*K+j];
        s = s >>> SH;
`ifdef CONV_RELU_EN
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
`else
        if (s < -128) s = -128;
        if (s > 127)  s = 127;
`endif
        return s[7:0];
    endfunction

    // Output monitor: checks hold stability and pops the scoreboard on each transfer.
    always @(negedge clk) begin
        if (reset) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", pxl_out, held_d);
                chk("hold_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                chk("result_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data", pxl_out, e.d);
                    chk("last", out_last, e.l);
                    if (!stall_mode) chk("latency", cyc - e.cyc, 2);
                end
                n_out++;
            end
            held_v = out_valid && !out_ready;
            held_d = pxl_out;
            held_l = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic load_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 8'(v);
        step();
        coef_we   = 1'b0;
    endtask

    // kind: 0 identity, 1 all ones, 2 all minus ones, 3 random small
    task automatic set_kernel(input int kind);
        for (int i = 0; i < K*K; i++) begin
            case (kind)
                0:       kern[i] = (i == K*K-1) ? 1 : 0;
                1:       kern[i] = 1;
                2:       kern[i] = -1;
                default: kern[i] = int'($urandom_range(0, 40)) - 20;
            endcase
            load_coef(i, kern[i]);
        end
        // Out-of-range indices must not disturb the bank.
        load_coef(25, 85);
        load_coef(31, -7);
    endtask

    task automatic send_pixel(input int r, input int c);
        bit acc;
        acc = 0;
        if (stall_mode && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            step();
        end
        in_valid = 1'b1;
        pxl_in   = 8'(img[r][c]);
        for (int t = 0; t < 1000 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && r >= K-1 && c >= K-1) begin
                exp_t e;
                e.d   = model(r, c);
                e.l   = (r == DIM-1) && (c == DIM-1);
                e.cyc = cyc;
                exp_q.push_back(e);
            end
            step();
        end
        chk("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int t = 0; t < 5000 && exp_q.size() != 0; t++) step();
        step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // mode: 0 ramp, 1 constant cval, 2 random; reset_at >= 0 aborts there with reset.
    task automatic run_frame(input int mode, input int cval, input int reset_at);
        n_out = 0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (mode)
                    0:       img[r][c] = (r*DIM + c) % 256;
                    1:       img[r][c] = cval;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
                if (r*DIM + c == reset_at) begin
                    in_valid = 1'b0;
                    reset = 1'b1;
                    @(negedge clk);
                    chk("midreset_valid", out_valid, 0);
                    chk("midreset_data", pxl_out, 0);
                    chk("midreset_last", out_last, 0);
                    exp_q.delete();
                    step();
                    reset = 1'b0;
                    for (int i = 0; i < K*K; i++) kern[i] = 0;
                    return;
                end
                send_pixel(r, c);
            end
        end
        drain();
        chk("frame_count", n_out, NRES);
    endtask

    initial begin
        reset = 1'b1;
        pxl_in = '0; in_valid = 1'b0; coef_we = 1'b0; coef_addr = '0;
        coef_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", pxl_out, 0);
        chk("reset_last", out_last, 0);
        chk("reset_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        set_kernel(0); run_frame(0, 0, -1);    // identity, ramp
        set_kernel(1); run_frame(1, 10, -1);   // ones, constant 10
        run_frame(1, 255, -1);                 // ones, constant 255 saturates
        set_kernel(2); run_frame(1, 100, -1);  // minus ones, constant 100

        stall_mode = 1;                        // backpressure and input gaps
        set_kernel(0); run_frame(0, 0, -1);
        set_kernel(3); run_frame(2, 0, -1);
        stall_mode = 0;
        step();

        set_kernel(0); run_frame(0, 0, 300);   // reset mid-frame
        run_frame(2, 0, -1);                   // cleared coefficients give zeros
        set_kernel(3); run_frame(2, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
